// File: rtl/gimbal_pkg.sv
// Shared types and unit constants for the gimbal actuator stage.
package gimbal_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_SAT   = 2'd2
    } gimbal_state_e;

    localparam int MDEG_PER_DEG      = 1000;
    localparam int UDEG_PER_DEG      = 1_000_000;
    localparam int DEFAULT_ANGLE_MAX = 5_000_000;
    localparam int DEFAULT_RATE_STEP = 500;

endpackage

// File: rtl/gimbal_actuator_sat_add.sv
// Signed N-bit add (or subtract when SUB=1) evaluated at N+1 bits, clamped to +/-limit.
module sat_add #(
    parameter int N   = 64,
    parameter bit SUB = 1'b0
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] limit,
    output logic [N-1:0] y,
    output logic         clamped
);

    logic signed [N:0] a_ext;
    logic signed [N:0] b_ext;
    logic signed [N:0] sum;
    logic signed [N:0] lim_pos;
    logic signed [N:0] lim_neg;

    always_comb begin
        a_ext   = {a[N-1], a};
        b_ext   = {b[N-1], b};
        sum     = SUB ? (a_ext - b_ext) : (a_ext + b_ext);
        lim_pos = {1'b0, limit};
        lim_neg = -lim_pos;
        y       = sum[N-1:0];
        clamped = 1'b0;
        // The extra bit means a wrapped N-bit result can never slip past the clamp.
        if (sum > lim_pos) begin
            y       = limit;
            clamped = 1'b1;
        end else if (sum < lim_neg) begin
            y       = lim_neg[N-1:0];
            clamped = 1'b1;
        end
    end

endmodule

// File: rtl/gimbal_actuator.sv
// Integrates commanded rate into a clamped gimbal angle once per tick.
// Optional slew limiting of the applied rate is enabled by defining GIMBAL_ACT_SLEW_EN.
module gimbal_actuator
    import gimbal_pkg::*;
#(
    parameter int N           = 64,
    parameter int TICK_CYCLES = 1000,
    parameter int ANGLE_MAX   = DEFAULT_ANGLE_MAX,
    parameter int RATE_STEP   = DEFAULT_RATE_STEP
) (
    input  logic         clk,
    input  logic         resetb,
    input  logic         enable,
    input  logic         cmd_valid,
    input  logic [N-1:0] angularVelocity,
    output logic         cmd_ready,
    output logic [N-1:0] angle,
    output logic         angle_valid,
    output logic [N-1:0] rate_applied,
    output logic         saturated,
    output logic [1:0]   state
);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_TRACK = ST_TRACK;
    localparam logic [1:0] S_SAT   = ST_SAT;

    localparam int               CNT_W    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     angle_q, angle_d;
    logic [N-1:0]     rate_applied_q, rate_applied_d;
    logic [N-1:0]     rate_cmd_q, rate_cmd_d;
    logic             saturated_q, saturated_d;
    logic             angle_valid_q, angle_valid_d;
    logic             cmd_ready_q, cmd_ready_d;

    logic [N-1:0]     rate_new;
    logic [N-1:0]     angle_sum;
    logic             angle_clamp;

`ifdef GIMBAL_ACT_SLEW_EN
    logic [N-1:0] slew_step;
    logic         slew_unused_clip;

    sat_add #(.N(N), .SUB(1'b1)) u_slew_clip (
        .a       (rate_cmd_q),
        .b       (rate_applied_q),
        .limit   (N'(RATE_STEP)),
        .y       (slew_step),
        .clamped (slew_unused_clip)
    );

    // Result always lies between the old applied rate and the command, so N bits suffice.
    assign rate_new = rate_applied_q + slew_step;
`else
    logic unused_rate_step;

    assign unused_rate_step = ^RATE_STEP;
    assign rate_new         = rate_cmd_q;
`endif

    sat_add #(.N(N), .SUB(1'b0)) u_angle_add (
        .a       (angle_q),
        .b       (rate_new),
        .limit   (N'(ANGLE_MAX)),
        .y       (angle_sum),
        .clamped (angle_clamp)
    );

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        angle_d        = angle_q;
        rate_applied_d = rate_applied_q;
        saturated_d    = saturated_q;
        angle_valid_d  = 1'b0;
        cmd_ready_d    = 1'b1;
        // Newest command wins; a command in the terminal cycle lands after the update uses the old one.
        rate_cmd_d     = cmd_valid ? angularVelocity : rate_cmd_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (enable) begin
                    state_d = S_TRACK;
                end
            end
            S_TRACK, S_SAT: begin
                if (!enable) begin
                    state_d        = S_IDLE;
                    cnt_d          = '0;
                    rate_applied_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d          = '0;
                    angle_d        = angle_sum;
                    rate_applied_d = rate_new;
                    saturated_d    = angle_clamp;
                    angle_valid_d  = 1'b1;
                    state_d        = angle_clamp ? S_SAT : S_TRACK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetb) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            angle_q        <= '0;
            rate_applied_q <= '0;
            rate_cmd_q     <= '0;
            saturated_q    <= 1'b0;
            angle_valid_q  <= 1'b0;
            cmd_ready_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            angle_q        <= angle_d;
            rate_applied_q <= rate_applied_d;
            rate_cmd_q     <= rate_cmd_d;
            saturated_q    <= saturated_d;
            angle_valid_q  <= angle_valid_d;
            cmd_ready_q    <= cmd_ready_d;
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign angle        = angle_q;
    assign angle_valid  = angle_valid_q;
    assign rate_applied = rate_applied_q;
    assign saturated    = saturated_q;
    assign state        = state_q;

endmodule

// File: tb/tb_gimbal_actuator.sv
// Bench for gimbal_actuator: directed vector table, hand sequences, and randomized run vs. a reference model.
module tb_gimbal_actuator;

    localparam int N    = 64;
    localparam int T    = 4;
    localparam int AMAX = 1000;
    localparam int RS   = 100;

    typedef logic signed [71:0] wide_t;

    typedef struct {
        bit     rst;
        bit     cv;
        longint cmd;
        longint e_angle;
        longint e_rate;
        bit     e_sat;
        int     e_state;
    } vec_t;

    logic          clk = 1'b0;
    logic          resetb;
    logic          enable;
    logic          cmd_valid;
    logic [N-1:0]  angularVelocity;
    logic          cmd_ready;
    logic [N-1:0]  angle;
    logic          angle_valid;
    logic [N-1:0]  rate_applied;
    logic          saturated;
    logic [1:0]    state;

    always #5 clk = ~clk;

    gimbal_actuator #(
        .N           (N),
        .TICK_CYCLES (T),
        .ANGLE_MAX   (AMAX),
        .RATE_STEP   (RS)
    ) dut (
        .clk             (clk),
        .resetb          (resetb),
        .enable          (enable),
        .cmd_valid       (cmd_valid),
        .angularVelocity (angularVelocity),
        .cmd_ready       (cmd_ready),
        .angle           (angle),
        .angle_valid     (angle_valid),
        .rate_applied    (rate_applied),
        .saturated       (saturated),
        .state           (state)
    );

    int total  = 0;
    int passed = 0;

    // Reference model state (spec-level behaviour, wide arithmetic so nothing wraps).
    bit    m_on;
    int    m_t;
    int    m_st;
    bit    m_sat;
    bit    m_valid;
    wide_t m_angle;
    wide_t m_rate;
    wide_t m_cmd;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, $signed(act), $signed(exp));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!angle_valid && n < 12);
    endtask

    task automatic do_reset();
        resetb    = 1'b1;
        enable    = 1'b0;
        cmd_valid = 1'b0;
        tick();
        resetb    = 1'b0;
    endtask

    function automatic vec_t mk(bit rst, bit cv, longint cmd, longint ea, longint er, bit es, int est);
        vec_t v;
        v.rst = rst; v.cv = cv; v.cmd = cmd;
        v.e_angle = ea; v.e_rate = er; v.e_sat = es; v.e_state = est;
        return v;
    endfunction

    task automatic model_step(input bit en, input bit cv, input logic [63:0] cmd);
        wide_t nr;
        wide_t s;
`ifdef GIMBAL_ACT_SLEW_EN
        wide_t d;
`endif
        m_valid = 1'b0;
        if (!m_on) begin
            if (en) begin
                m_on = 1'b1;
                m_t  = 0;
                m_st = 1;
            end
        end else if (!en) begin
            m_on   = 1'b0;
            m_rate = '0;
            m_st   = 0;
        end else if (m_t == T - 1) begin
`ifdef GIMBAL_ACT_SLEW_EN
            d = m_cmd - m_rate;
            if (d > RS) d = RS;
            else if (d < -RS) d = -RS;
            nr = m_rate + d;
`else
            nr = m_cmd;
`endif
            s = m_angle + nr;
            if (s > AMAX) begin
                m_angle = AMAX;
                m_sat   = 1'b1;
            end else if (s < -AMAX) begin
                m_angle = -AMAX;
                m_sat   = 1'b1;
            end else begin
                m_angle = s;
                m_sat   = 1'b0;
            end
            m_rate  = nr;
            m_t     = 0;
            m_valid = 1'b1;
            m_st    = m_sat ? 2 : 1;
        end else begin
            m_t++;
        end
        if (cv) m_cmd = {{8{cmd[63]}}, cmd};
    endtask

    initial begin
        vec_t        vecs[$];
        int          n;
        int          cnt;
        bit          en;
        bit          cv;
        logic [63:0] cmd;
        longint      v;

`ifdef GIMBAL_ACT_SLEW_EN
        vecs.push_back(mk(1, 1, 350,  100, 100, 0, 1));
        vecs.push_back(mk(0, 0, 0,    300, 200, 0, 1));
        vecs.push_back(mk(0, 0, 0,    600, 300, 0, 1));
        vecs.push_back(mk(0, 0, 0,    950, 350, 0, 1));
        vecs.push_back(mk(0, 0, 0,   1000, 350, 1, 2));
        vecs.push_back(mk(0, 1, -300, 1000, 250, 1, 2));
        vecs.push_back(mk(0, 0, 0,   1000, 150, 1, 2));
        vecs.push_back(mk(0, 0, 0,   1000,  50, 1, 2));
        vecs.push_back(mk(0, 0, 0,    950, -50, 0, 1));
`else
        vecs.push_back(mk(1, 1, 50,    50,  50, 0, 1));
        vecs.push_back(mk(0, 0, 0,    100,  50, 0, 1));
        vecs.push_back(mk(0, 0, 0,    150,  50, 0, 1));
        vecs.push_back(mk(1, 1, 400,  400, 400, 0, 1));
        vecs.push_back(mk(0, 0, 0,    800, 400, 0, 1));
        vecs.push_back(mk(0, 0, 0,   1000, 400, 1, 2));
        vecs.push_back(mk(0, 1, -300, 700, -300, 0, 1));
        vecs.push_back(mk(0, 1, -2000, -1000, -2000, 1, 2));
        vecs.push_back(mk(0, 1, 64'sh7FFF_FFFF_FFFF_FFFF, 1000, 64'sh7FFF_FFFF_FFFF_FFFF, 1, 2));
        vecs.push_back(mk(0, 0, 0,   1000, 64'sh7FFF_FFFF_FFFF_FFFF, 1, 2));
        vecs.push_back(mk(0, 1, 64'sh8000_0000_0000_0000, -1000, 64'sh8000_0000_0000_0000, 1, 2));
`endif

        // Reset asserted mid-tick after a real update.
        resetb = 1'b1; enable = 1'b0; cmd_valid = 1'b0; angularVelocity = '0;
        tick(); tick();
        resetb = 1'b0;
        tick();
        enable = 1'b1; cmd_valid = 1'b1; angularVelocity = 64'd50;
        tick();
        cmd_valid = 1'b0;
        wait_valid(n);
        chk("pre_rst_angle", angle, 64'd50);
        tick();
        resetb = 1'b1; enable = 1'b0;
        tick();
        chk("rst_angle", angle, 64'd0);
        chk("rst_rate", rate_applied, 64'd0);
        chk("rst_sat", saturated, 64'd0);
        chk("rst_valid", angle_valid, 64'd0);
        chk("rst_state", state, 64'd0);
        chk("rst_ready", cmd_ready, 64'd0);
        resetb = 1'b0;
        tick();
        chk("ready_after_rst", cmd_ready, 64'd1);
        cnt = 0;
        repeat (20) begin
            tick();
            if (angle_valid) cnt++;
        end
        chk("idle_pulses", cnt, 64'd0);
        enable = 1'b1;
        wait_valid(n);
        chk("first_latency", n, 64'd5);
        chk("rst_cmd_rate", rate_applied, 64'd0);

        // Directed vector table.
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) begin
                do_reset();
                enable = 1'b1;
            end
            if (vecs[i].cv) begin
                cmd_valid       = 1'b1;
                angularVelocity = vecs[i].cmd;
            end
            tick();
            cmd_valid = 1'b0;
            wait_valid(n);
            chk($sformatf("v%0d_valid", i), angle_valid, 64'd1);
            chk($sformatf("v%0d_angle", i), angle, vecs[i].e_angle);
            chk($sformatf("v%0d_rate", i), rate_applied, vecs[i].e_rate);
            chk($sformatf("v%0d_sat", i), saturated, 64'(vecs[i].e_sat));
            chk($sformatf("v%0d_state", i), state, 64'(vecs[i].e_state));
        end

        // Command arriving in the terminal-count cycle.
        do_reset();
        enable = 1'b1; cmd_valid = 1'b1; angularVelocity = 64'd10;
        tick();
        cmd_valid = 1'b0;
        wait_valid(n);
        chk("col_first", angle, 64'd10);
        repeat (3) tick();
        cmd_valid = 1'b1; angularVelocity = 64'd20;
        tick();
        cmd_valid = 1'b0;
        chk("col_valid", angle_valid, 64'd1);
        chk("col_angle", angle, 64'd20);
        chk("col_rate", rate_applied, 64'd10);
        wait_valid(n);
        chk("col_next_angle", angle, 64'd40);
        chk("col_next_rate", rate_applied, 64'd20);

        // Disable and re-enable.
        do_reset();
        enable = 1'b1; cmd_valid = 1'b1; angularVelocity = 64'd100;
        tick();
        cmd_valid = 1'b0;
        repeat (3) wait_valid(n);
        chk("dis_pre_angle", angle, 64'd300);
        enable = 1'b0;
        tick();
        chk("dis_state", state, 64'd0);
        chk("dis_rate", rate_applied, 64'd0);
        chk("dis_angle", angle, 64'd300);
        cnt = 0;
        repeat (4) begin
            if (angle_valid) cnt++;
            tick();
        end
        chk("dis_pulses", cnt, 64'd0);
        enable = 1'b1;
        wait_valid(n);
        chk("reen_latency", n, 64'd5);
        chk("reen_angle", angle, 64'd400);

        // Randomized run against the reference model.
        do_reset();
        m_on = 1'b0; m_t = 0; m_st = 0; m_sat = 1'b0; m_valid = 1'b0;
        m_angle = '0; m_rate = '0; m_cmd = '0;
        en = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 39) == 0) en = ~en;
            cv = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 19))
                0:       cmd = 64'h7FFF_FFFF_FFFF_FFFF;
                1:       cmd = 64'h8000_0000_0000_0000;
                default: begin
                    v   = longint'($urandom_range(0, 900)) - 64'sd450;
                    cmd = v;
                end
            endcase
            enable = en; cmd_valid = cv; angularVelocity = cmd;
            model_step(en, cv, cmd);
            tick();
            chk("rand_angle", angle, m_angle[63:0]);
            chk("rand_rate", rate_applied, m_rate[63:0]);
            chk("rand_sat", saturated, 64'(m_sat));
            chk("rand_state", state, 64'(m_st));
            chk("rand_valid", angle_valid, 64'(m_valid));
        end

        cmd_valid = 1'b0;
        enable    = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
